// File: rtl/kernel_seq_ctrl_pkg.sv
// kernel_seq_ctrl_pkg
// Shared definitions for the kernel sequencer: accumulator mode encodings,
// default accumulator latencies, the sequencer FSM state type and a mode
// legality helper.
package kernel_seq_ctrl_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_CONV = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;

    localparam int unsigned LAT_CONV_DEF = 6;
    localparam int unsigned LAT_SUB_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } ksc_state_e;

    function automatic logic mode_legal(input logic [1:0] mode);
        return (mode == MODE_CONV) || (mode == MODE_SUB);
    endfunction

endpackage

// File: rtl/ksc_out_fifo.sv
// ksc_out_fifo
// Synchronous first-word-fall-through FIFO holding per-pixel sums.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push         write push_data (never issued when full)
//   push_data    entry to write
//   pop          consume the head entry; ignored when empty
//   head_vld     FIFO non-empty
//   head_data    head entry, forced to 0 when empty
//   count        number of stored entries
module ksc_out_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic                     head_vld,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_eff;

    assign pop_eff = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop_eff);
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // The credit scheme upstream guarantees a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            assert (count_q < CW'(DEPTH));
        end
    end

    assign head_vld  = (count_q != '0);
    assign head_data = head_vld ? mem[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/kernel_seq_ctrl.sv
// kernel_seq_ctrl
// Sequences multiplier beats into the column accumulator, tracks each beat
// through the accumulator latency with a tagged delay line, sums per-row
// kernel partials into one result per pixel and buffers results in an
// output FIFO whose credits back-pressure the multiplier array.
// Build option: KSC_SAT_EN -- saturate per-pixel sums instead of wrapping.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_start        job start pulse (IDLE only), i_mode/i_rows/i_npix config
//   o_busy         job active; o_err illegal-start pulse; o_done last push
//   o_mul_loop     accumulator mode, MODE_OFF when idle
//   i_mul_vld      beat present; o_mul_rdy beat accepted when both high
//   i_acc_kernel   accumulator partial, LAT cycles after the beat
//   o_pix_vld      FIFO head valid; i_pix_rdy pop; o_pix_sum head data
module kernel_seq_ctrl
    import kernel_seq_ctrl_pkg::*;
#(
    parameter int unsigned AK_BW      = 20,
    parameter int unsigned SUM_BW     = 24,
    parameter int unsigned LAT_CONV   = LAT_CONV_DEF,
    parameter int unsigned LAT_SUB    = LAT_SUB_DEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned NPIX_BW    = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic [2:0]         i_rows,
    input  logic [NPIX_BW-1:0] i_npix,
    output logic               o_busy,
    output logic               o_err,
    output logic               o_done,
    output logic [1:0]         o_mul_loop,
    input  logic               i_mul_vld,
    output logic               o_mul_rdy,
    input  logic [AK_BW-1:0]   i_acc_kernel,
    output logic               o_pix_vld,
    input  logic               i_pix_rdy,
    output logic [SUM_BW-1:0]  o_pix_sum
);

    localparam int unsigned CNT_BW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CS_BW  = CNT_BW + 1;

    ksc_state_e         state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [2:0]         rows_q, rows_d;
    logic [NPIX_BW-1:0] npix_q, npix_d;
    logic [2:0]         row_cnt_q, row_cnt_d;
    logic [NPIX_BW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_BW-1:0]  inflight_q, inflight_d;
    logic [SUM_BW-1:0]  sum_q, sum_d;
    logic               err_q, err_d;
    logic [LAT_CONV-1:0] dl_vld_q, dl_vld_d;
    logic [LAT_CONV-1:0] dl_first_q, dl_first_d;
    logic [LAT_CONV-1:0] dl_last_q, dl_last_d;

    logic [CNT_BW-1:0]  fifo_count;
    logic               start_legal, credit_ok, mul_rdy, accept;
    logic               beat_first, beat_last;
    logic               tap_vld, tap_first, tap_last, pend;
    logic               push, done;
    int                 tap_idx;
    logic [SUM_BW-1:0]  kern_ext, add_res, acc_val;
`ifdef KSC_SAT_EN
    logic [SUM_BW:0]    add_full;
`endif

    assign start_legal = mode_legal(i_mode) && (i_rows != 3'd0) && (i_rows <= 3'd5)
                         && (i_npix != '0);
    assign credit_ok   = ({1'b0, inflight_q} + {1'b0, fifo_count}) < CS_BW'(FIFO_DEPTH);
    assign mul_rdy     = (state_q == RUN) && ((row_cnt_q != 3'd0) || credit_ok);
    assign accept      = i_mul_vld && mul_rdy;
    assign beat_first  = (row_cnt_q == 3'd0);
    assign beat_last   = (row_cnt_q == rows_q - 3'd1);
    assign tap_idx     = (mode_q == MODE_SUB) ? int'(LAT_SUB) - 1 : int'(LAT_CONV) - 1;

    // Tap selection and "anything still in flight ahead of the tap".
    always_comb begin
        tap_vld   = 1'b0;
        tap_first = 1'b0;
        tap_last  = 1'b0;
        pend      = 1'b0;
        for (int i = 0; i < int'(LAT_CONV); i++) begin
            if (i == tap_idx) begin
                tap_vld   = dl_vld_q[i];
                tap_first = dl_first_q[i];
                tap_last  = dl_last_q[i];
            end else if (i < tap_idx) begin
                pend = pend | dl_vld_q[i];
            end
        end
    end

    // Delay line shift; a tag is dropped once consumed at the tap.
    always_comb begin
        dl_vld_d      = '0;
        dl_first_d    = '0;
        dl_last_d     = '0;
        dl_vld_d[0]   = accept;
        dl_first_d[0] = accept && beat_first;
        dl_last_d[0]  = accept && beat_last;
        for (int i = 1; i < int'(LAT_CONV); i++) begin
            if (i - 1 != tap_idx) begin
                dl_vld_d[i]   = dl_vld_q[i-1];
                dl_first_d[i] = dl_first_q[i-1];
                dl_last_d[i]  = dl_last_q[i-1];
            end
        end
    end

    // Per-pixel accumulation.
    always_comb begin
        kern_ext = SUM_BW'(i_acc_kernel);
`ifdef KSC_SAT_EN
        add_full = {1'b0, sum_q} + {1'b0, kern_ext};
        add_res  = add_full[SUM_BW] ? '1 : add_full[SUM_BW-1:0];
`else
        add_res  = sum_q + kern_ext;
`endif
        acc_val = tap_first ? kern_ext : add_res;
        sum_d   = tap_vld ? acc_val : sum_q;
    end

    assign push = tap_vld && tap_last;
    assign done = (state_q == DRAIN) && push && !pend;

    // FSM next state and counters.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rows_d     = rows_q;
        npix_d     = npix_q;
        row_cnt_d  = row_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        err_d      = 1'b0;
        inflight_d = inflight_q + CNT_BW'(accept && beat_first) - CNT_BW'(push);
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (start_legal) begin
                        state_d   = RUN;
                        mode_d    = i_mode;
                        rows_d    = i_rows;
                        npix_d    = i_npix;
                        row_cnt_d = 3'd0;
                        pix_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (beat_last) begin
                        row_cnt_d = 3'd0;
                        pix_cnt_d = pix_cnt_q + NPIX_BW'(1);
                        if (pix_cnt_q == npix_q - NPIX_BW'(1)) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + 3'd1;
                    end
                end
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_OFF;
            rows_q     <= 3'd0;
            npix_q     <= '0;
            row_cnt_q  <= 3'd0;
            pix_cnt_q  <= '0;
            inflight_q <= '0;
            sum_q      <= '0;
            err_q      <= 1'b0;
            dl_vld_q   <= '0;
            dl_first_q <= '0;
            dl_last_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            rows_q     <= rows_d;
            npix_q     <= npix_d;
            row_cnt_q  <= row_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            inflight_q <= inflight_d;
            sum_q      <= sum_d;
            err_q      <= err_d;
            dl_vld_q   <= dl_vld_d;
            dl_first_q <= dl_first_d;
            dl_last_q  <= dl_last_d;
        end
    end

    ksc_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (SUM_BW)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (acc_val),
        .pop       (i_pix_rdy),
        .head_vld  (o_pix_vld),
        .head_data (o_pix_sum),
        .count     (fifo_count)
    );

    assign o_busy     = (state_q != IDLE);
    assign o_err      = err_q;
    assign o_done     = done;
    assign o_mul_loop = (state_q == IDLE) ? MODE_OFF : mode_q;
    assign o_mul_rdy  = mul_rdy;

endmodule

// File: tb/tb_kernel_seq_ctrl.sv
module tb_kernel_seq_ctrl;

    localparam int AK_BW   = 20;
    localparam int SUM_BW  = 21;
    localparam int NPIX_BW = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic [1:0]         i_mode = 2'b00;
    logic [2:0]         i_rows = 3'd0;
    logic [NPIX_BW-1:0] i_npix = '0;
    logic               o_busy, o_err, o_done, o_mul_rdy, o_pix_vld;
    logic [1:0]         o_mul_loop;
    logic               i_mul_vld = 1'b0;
    logic [AK_BW-1:0]   i_acc_kernel = '0;
    logic               i_pix_rdy = 1'b0;
    logic [SUM_BW-1:0]  o_pix_sum;

    kernel_seq_ctrl #(
        .AK_BW      (AK_BW),
        .SUM_BW     (SUM_BW),
        .LAT_CONV   (6),
        .LAT_SUB    (5),
        .FIFO_DEPTH (8),
        .NPIX_BW    (NPIX_BW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_rows       (i_rows),
        .i_npix       (i_npix),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_done       (o_done),
        .o_mul_loop   (o_mul_loop),
        .i_mul_vld    (i_mul_vld),
        .o_mul_rdy    (o_mul_rdy),
        .i_acc_kernel (i_acc_kernel),
        .o_pix_vld    (o_pix_vld),
        .i_pix_rdy    (i_pix_rdy),
        .o_pix_sum    (o_pix_sum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 6;
    logic [AK_BW-1:0]  kern_at [64];
    logic [AK_BW-1:0]  beats [$];
    logic [SUM_BW-1:0] got [$];
    int                acc_cyc [$];
    int done_cnt, first_vld_cyc, loop_bad;
    logic [1:0] exp_loop;

    // One clock cycle: sample the ending cycle, advance, drive the
    // accumulator model output for the new cycle.
    task automatic tick();
        #1;
        if (o_pix_vld && i_pix_rdy) got.push_back(o_pix_sum);
        if (o_done) done_cnt++;
        if (o_pix_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (o_busy && o_mul_loop !== exp_loop) loop_bad++;
        if (i_mul_vld && o_mul_rdy && beats.size() > 0) begin
            acc_cyc.push_back(cyc);
            kern_at[(cyc + lat) % 64] = beats.pop_front();
        end
        @(posedge clk);
        #1;
        cyc++;
        i_acc_kernel = kern_at[cyc % 64];
        kern_at[cyc % 64] = '0;
    endtask

    task automatic clear_state(input int new_lat, input logic [1:0] loop_mode);
        got.delete();
        beats.delete();
        acc_cyc.delete();
        for (int i = 0; i < 64; i++) kern_at[i] = '0;
        done_cnt = 0;
        first_vld_cyc = -1;
        loop_bad = 0;
        lat = new_lat;
        exp_loop = loop_mode;
    endtask

    task automatic start_job(input logic [1:0] m, input logic [2:0] r, input int n);
        i_mode = m;
        i_rows = r;
        i_npix = NPIX_BW'(n);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic drive_beats(input int budget);
        int n;
        n = 0;
        while (beats.size() > 0 && n < budget) begin
            i_mul_vld = 1'b1;
            tick();
            n++;
        end
        i_mul_vld = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n, d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout: o_done not seen within %0d cycles", name, budget);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_fall: o_busy=%b required 0", name, o_busy);
        end
    endtask

    task automatic wait_results(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (got.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d results required %0d", name, got.size(), n);
        end
    endtask

    task automatic check_sum(input string name, input int idx, input logic [SUM_BW-1:0] exp);
        checks++;
        if (got.size() <= idx || got[idx] !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h required %h", name, idx,
                     (got.size() > idx) ? got[idx] : 'x, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({o_busy, o_err, o_done, o_mul_loop, o_mul_rdy, o_pix_vld, o_pix_sum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b err=%b done=%b loop=%b rdy=%b vld=%b sum=%h required all 0",
                     o_busy, o_err, o_done, o_mul_loop, o_mul_rdy, o_pix_vld, o_pix_sum);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({o_busy, o_err, o_mul_loop, o_mul_rdy, o_pix_vld} !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b err=%b loop=%b rdy=%b vld=%b required 0",
                     o_busy, o_err, o_mul_loop, o_mul_rdy, o_pix_vld);
        end
    endtask

    task automatic test_conv();
        clear_state(6, 2'b01);
        i_pix_rdy = 1'b1;
        beats = '{20'd10, 20'd20, 20'd30, 20'd1, 20'd2, 20'd3};
        start_job(2'b01, 3'd3, 2);
        checks++;
        if (o_busy !== 1'b1 || o_mul_loop !== 2'b01) begin
            errors++;
            $display("FAIL conv_start: busy=%b loop=%b required 1/01", o_busy, o_mul_loop);
        end
        drive_beats(20);
        wait_done("conv", 40);
        wait_results("conv", 2, 20);
        check_sum("conv_sum", 0, 21'd60);
        check_sum("conv_sum", 1, 21'd6);
        checks++;
        if (acc_cyc.size() < 3 || first_vld_cyc - acc_cyc[2] != 7) begin
            errors++;
            $display("FAIL conv_latency: first vld %0d cycles after third beat required 7",
                     (acc_cyc.size() < 3) ? -1 : first_vld_cyc - acc_cyc[2]);
        end
        checks++;
        if (acc_cyc.size() == 6 && acc_cyc[5] - acc_cyc[0] != 5) begin
            errors++;
            $display("FAIL conv_b2b: beats spanned %0d cycles required 5", acc_cyc[5] - acc_cyc[0]);
        end
        checks++;
        if (done_cnt != 1 || loop_bad != 0) begin
            errors++;
            $display("FAIL conv_done_once: done pulses %0d loop errors %0d required 1/0",
                     done_cnt, loop_bad);
        end
    endtask

    task automatic test_sub();
        clear_state(5, 2'b10);
        i_pix_rdy = 1'b1;
        beats = '{20'd5, 20'd6, 20'd7, 20'd8};
        start_job(2'b10, 3'd1, 4);
        drive_beats(20);
        wait_done("sub", 40);
        wait_results("sub", 4, 20);
        for (int i = 0; i < 4; i++) check_sum("sub_sum", i, SUM_BW'(5 + i));
        checks++;
        if (acc_cyc.size() < 1 || first_vld_cyc - acc_cyc[0] != 6) begin
            errors++;
            $display("FAIL sub_latency: first vld %0d cycles after first beat required 6",
                     (acc_cyc.size() < 1) ? -1 : first_vld_cyc - acc_cyc[0]);
        end
        checks++;
        if (loop_bad != 0) begin
            errors++;
            $display("FAIL sub_loop: %0d busy cycles with o_mul_loop != 10", loop_bad);
        end
    endtask

    task automatic test_backpressure();
        clear_state(6, 2'b01);
        i_pix_rdy = 1'b0;
        for (int i = 1; i <= 10; i++) beats.push_back(AK_BW'(i));
        start_job(2'b01, 3'd1, 10);
        drive_beats(30);
        checks++;
        if (acc_cyc.size() != 8 || o_mul_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_credit: accepted %0d rdy=%b required 8/0", acc_cyc.size(), o_mul_rdy);
        end
        checks++;
        if (o_pix_vld !== 1'b1 || o_pix_sum !== 21'd1) begin
            errors++;
            $display("FAIL bp_head: vld=%b sum=%h required 1/1", o_pix_vld, o_pix_sum);
        end
        i_pix_rdy = 1'b1;
        drive_beats(40);
        wait_done("bp", 40);
        wait_results("bp", 10, 40);
        for (int i = 0; i < 10; i++) check_sum("bp_sum", i, SUM_BW'(i + 1));
    endtask

    task automatic test_illegal();
        logic [1:0] modes [4];
        logic [2:0] rows [4];
        int         npix [4];
        modes = '{2'b01, 2'b11, 2'b10, 2'b00};
        rows  = '{3'd0, 3'd1, 3'd6, 3'd2};
        npix  = '{1, 1, 1, 0};
        clear_state(6, 2'b00);
        for (int v = 0; v < 4; v++) begin
            start_job(modes[v], rows[v], npix[v]);
            checks++;
            if (o_err !== 1'b1 || o_busy !== 1'b0 || o_mul_loop !== 2'b00) begin
                errors++;
                $display("FAIL illegal_%0d: err=%b busy=%b loop=%b required 1/0/00",
                         v, o_err, o_busy, o_mul_loop);
            end
            tick();
            checks++;
            if (o_err !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse_%0d: err=%b busy=%b required 0/0", v, o_err, o_busy);
            end
        end
    endtask

    task automatic test_saturation();
        logic [SUM_BW-1:0] exp;
`ifdef KSC_SAT_EN
        exp = 21'h1FFFFF;
`else
        exp = 21'h0FFFFD;
`endif
        clear_state(6, 2'b01);
        i_pix_rdy = 1'b1;
        beats = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
        start_job(2'b01, 3'd3, 1);
        drive_beats(20);
        wait_done("sat", 40);
        wait_results("sat", 1, 20);
        check_sum("sat_sum", 0, exp);
    endtask

    task automatic test_reset_mid_run();
        clear_state(6, 2'b01);
        i_pix_rdy = 1'b0;
        beats = '{20'd11, 20'd12, 20'd13};
        start_job(2'b01, 3'd1, 6);
        drive_beats(10);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (o_busy !== 1'b1 || o_pix_vld !== 1'b1 || o_pix_sum !== 21'd11) begin
            errors++;
            $display("FAIL rst_pre: busy=%b vld=%b sum=%h required 1/1/11",
                     o_busy, o_pix_vld, o_pix_sum);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_err, o_done, o_mul_loop, o_mul_rdy, o_pix_vld, o_pix_sum} !== '0) begin
            errors++;
            $display("FAIL rst_async: busy=%b err=%b done=%b loop=%b rdy=%b vld=%b sum=%h required all 0",
                     o_busy, o_err, o_done, o_mul_loop, o_mul_rdy, o_pix_vld, o_pix_sum);
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear_state(6, 2'b01);
        i_pix_rdy = 1'b1;
        beats = '{20'd4, 20'd9};
        start_job(2'b01, 3'd2, 1);
        drive_beats(10);
        wait_done("rst_job", 30);
        wait_results("rst_job", 1, 20);
        for (int i = 0; i < 5; i++) tick();
        check_sum("rst_job_sum", 0, 21'd13);
        checks++;
        if (got.size() != 1) begin
            errors++;
            $display("FAIL rst_flush: %0d results after reset job required 1", got.size());
        end
    endtask

    initial begin
        clear_state(6, 2'b00);
        test_reset();
        test_conv();
        test_sub();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
